// File: rtl/calc_pkg.sv
// Shared types, key-priority encoding and helpers for the calculator arithmetic core.
package calc_pkg;

  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;
  typedef enum logic [1:0] {IDLE, MUL_RUN, ERROR} state_t;
  typedef enum logic [2:0] {EV_NONE, EV_DIGIT, EV_ADD, EV_SUB, EV_MUL, EV_EQ, EV_CLR} ev_t;

  // Packed key vector layout: digits in [9:0], then ops in rising priority.
  localparam int unsigned NUM_DIGIT_KEYS = 10;
  localparam int unsigned K_MUL          = 10;
  localparam int unsigned K_SUB          = 11;
  localparam int unsigned K_ADD          = 12;
  localparam int unsigned K_EQ           = 13;
  localparam int unsigned K_CLR          = 14;
  localparam int unsigned KEY_W          = 15;

  function automatic longint unsigned max_mag(input int unsigned digits);
    longint unsigned m;
    m = 64'd1;
    for (int unsigned i = 0; i < digits; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  function automatic op_t ev_to_op(input ev_t ev);
    case (ev)
      EV_ADD:  return OP_ADD;
      EV_SUB:  return OP_SUB;
      EV_MUL:  return OP_MUL;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_accumulator_if.sv
// Keypad inputs and display-side outputs of the calculator arithmetic core.
interface calc_accumulator_if #(
  parameter int unsigned VAL_W = 28,
  parameter int unsigned LEN_W = 4
);
  logic [9:0]              key_digit;
  logic                    key_add;
  logic                    key_sub;
  logic                    key_mul;
  logic                    key_eq;
  logic                    key_clr;
  logic signed [VAL_W-1:0] disp_val;
  logic [LEN_W-1:0]        entry_len;
  logic                    busy;
  logic                    err;
  logic                    res_valid;

  modport master (
    output key_digit, key_add, key_sub, key_mul, key_eq, key_clr,
    input  disp_val, entry_len, busy, err, res_valid
  );

  modport slave (
    input  key_digit, key_add, key_sub, key_mul, key_eq, key_clr,
    output disp_val, entry_len, busy, err, res_valid
  );
endinterface

// File: rtl/calc_accumulator_seq_multiplier.sv
// Iterative shift-add multiplier on unsigned magnitudes, one multiplier bit per cycle.
module seq_multiplier #(
  parameter int unsigned W = 27
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a_mag,
  input  logic [W-1:0]   b_mag,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int unsigned PW    = 2 * W;
  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [PW-1:0]    mcand_q;
  logic [W-1:0]     mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  // Bit 0 is folded into the start cycle so W bits take exactly W cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done     <= 1'b0;
      prod     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand_q  <= PW'(a_mag) << 1;
        mplier_q <= b_mag >> 1;
        prod     <= b_mag[0] ? PW'(a_mag) : '0;
        cnt_q    <= CNT_W'(W - 1);
        run_q    <= (W > 1);
        done     <= (W == 1);
      end else if (run_q) begin
        if (mplier_q[0]) prod <= prod + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_accumulator.sv
// Keypad-driven signed accumulator with chained add/sub/mul, overflow error state and sequential multiply.
module calc_accumulator
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned VAL_W  = 28
) (
  input logic               clk,
  input logic               rst,
  calc_accumulator_if.slave bus
);

  localparam int unsigned LEN_W  = $clog2(DIGITS + 1);
  localparam int unsigned MAG_W  = VAL_W - 1;
  localparam int unsigned SUM_W  = VAL_W + 1;
  localparam int unsigned PROD_W = 2 * MAG_W;

  localparam logic signed [SUM_W-1:0] MAX_SUM  = SUM_W'(max_mag(DIGITS));
  localparam logic [PROD_W-1:0]       MAX_PROD = PROD_W'(max_mag(DIGITS));
  localparam logic [LEN_W-1:0]        LEN_FULL = LEN_W'(DIGITS);

  logic [KEY_W-1:0] key_raw, key_q, key_prev, key_rise;

  state_t                  state_q, state_d;
  op_t                     pend_q, pend_d;
  logic signed [VAL_W-1:0] acc_q, acc_d;
  logic [VAL_W-1:0]        entry_q, entry_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic signed [VAL_W-1:0] disp_q, disp_d;
  logic                    neg_q, neg_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    valid_q, valid_d;

  ev_t                     ev_c;
  op_t                     new_op_c;
  logic [3:0]              ev_digit_c;
  logic signed [SUM_W-1:0] sum_c, diff_c, res_c;
  logic                    res_ovf_c;
  logic [MAG_W-1:0]        acc_mag_c;
  logic signed [VAL_W-1:0] mul_mag_c, mul_res_c;
  logic                    mul_ovf_c;
  logic                    mul_start_c;
  logic                    mul_done;
  logic [PROD_W-1:0]       mul_prod;

  assign key_raw  = {bus.key_clr, bus.key_eq, bus.key_add, bus.key_sub, bus.key_mul, bus.key_digit};
  assign key_rise = key_q & ~key_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q    <= '0;
      key_prev <= '0;
    end else begin
      key_q    <= key_raw;
      key_prev <= key_q;
    end
  end

  // Later assignments win: lowest digit, then ops in rising priority up to clr.
  always_comb begin
    ev_c       = EV_NONE;
    ev_digit_c = '0;
    for (int i = int'(NUM_DIGIT_KEYS) - 1; i >= 0; i--) begin
      if (key_rise[i]) begin
        ev_c       = EV_DIGIT;
        ev_digit_c = 4'(i);
      end
    end
    if (key_rise[K_MUL]) ev_c = EV_MUL;
    if (key_rise[K_SUB]) ev_c = EV_SUB;
    if (key_rise[K_ADD]) ev_c = EV_ADD;
    if (key_rise[K_EQ])  ev_c = EV_EQ;
    if (key_rise[K_CLR]) ev_c = EV_CLR;
  end

  assign new_op_c = ev_to_op(ev_c);

  // One extra bit of headroom so the overflow compare never sees a wrapped value.
  assign sum_c  = $signed({acc_q[VAL_W-1], acc_q}) + $signed({1'b0, entry_q});
  assign diff_c = $signed({acc_q[VAL_W-1], acc_q}) - $signed({1'b0, entry_q});

  always_comb begin
    case (pend_q)
      OP_ADD:  res_c = sum_c;
      OP_SUB:  res_c = diff_c;
      default: res_c = $signed({1'b0, entry_q});
    endcase
  end

  assign res_ovf_c = (res_c > MAX_SUM) || (res_c < -MAX_SUM);

  assign acc_mag_c = MAG_W'(acc_q[VAL_W-1] ? -acc_q : acc_q);
  assign mul_mag_c = $signed({1'b0, mul_prod[MAG_W-1:0]});
  assign mul_res_c = neg_q ? -mul_mag_c : mul_mag_c;
  assign mul_ovf_c = mul_prod > MAX_PROD;

  seq_multiplier #(.W(MAG_W)) u_mul (
    .clk   (clk),
    .rst_n (rst),
    .start (mul_start_c),
    .a_mag (acc_mag_c),
    .b_mag (entry_q[MAG_W-1:0]),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    acc_d       = acc_q;
    entry_d     = entry_q;
    len_d       = len_q;
    disp_d      = disp_q;
    neg_d       = neg_q;
    valid_d     = 1'b0;
    mul_start_c = 1'b0;

    case (state_q)
      IDLE: begin
        case (ev_c)
          EV_CLR: begin
            acc_d   = '0;
            entry_d = '0;
            len_d   = '0;
            disp_d  = '0;
            pend_d  = OP_NONE;
          end
          EV_DIGIT: begin
            if (len_q < LEN_FULL) begin
              entry_d = entry_q * VAL_W'(10) + VAL_W'(ev_digit_c);
              len_d   = len_q + 1'b1;
              disp_d  = $signed(entry_d);
            end
          end
          EV_ADD, EV_SUB, EV_MUL, EV_EQ: begin
            if (pend_q == OP_MUL) begin
              mul_start_c = 1'b1;
              neg_d       = acc_q[VAL_W-1];
              pend_d      = new_op_c;
              state_d     = MUL_RUN;
            end else if (res_ovf_c) begin
              state_d = ERROR;
              acc_d   = '0;
              entry_d = '0;
              len_d   = '0;
              disp_d  = '0;
              pend_d  = OP_NONE;
            end else begin
              acc_d   = VAL_W'(res_c);
              disp_d  = VAL_W'(res_c);
              entry_d = '0;
              len_d   = '0;
              pend_d  = new_op_c;
              valid_d = (new_op_c == OP_NONE);
            end
          end
          default: ;
        endcase
      end
      MUL_RUN: begin
        // pend_q already holds the op that launched the multiply; NONE means it was equals.
        if (mul_done) begin
          state_d = mul_ovf_c ? ERROR : IDLE;
          acc_d   = mul_ovf_c ? '0 : mul_res_c;
          disp_d  = mul_ovf_c ? '0 : mul_res_c;
          entry_d = '0;
          len_d   = '0;
          pend_d  = mul_ovf_c ? OP_NONE : pend_q;
          valid_d = !mul_ovf_c && (pend_q == OP_NONE);
        end
      end
      ERROR: begin
        if (ev_c == EV_CLR) begin
          state_d = IDLE;
          acc_d   = '0;
          entry_d = '0;
          len_d   = '0;
          disp_d  = '0;
          pend_d  = OP_NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MUL_RUN);
    err_d  = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= OP_NONE;
      acc_q   <= '0;
      entry_q <= '0;
      len_q   <= '0;
      disp_q  <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      entry_q <= entry_d;
      len_q   <= len_d;
      disp_q  <= disp_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bus.disp_val  = disp_q;
  assign bus.entry_len = len_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.res_valid = valid_q;

endmodule
